// File: rtl/dfc_mc_receiver.sv
// Multi-channel delayed-flow-control receiver with per-channel FIFOs and a round-robin drain.
// Optional macro DFC_RX_HYSTERESIS_EN adds lo_threshold hysteresis to the per-channel fc_n.
module dfc_mc_receiver #(
  parameter int width        = 8,
  parameter int channels     = 4,
  parameter int depth        = 8,
  parameter int threshold    = 2,
  parameter int lo_threshold = 1,
  parameter int cw           = (channels > 1) ? $clog2(channels) : 1,
  parameter int asz          = $clog2(depth + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c_vld,
  input  logic [cw-1:0]             c_chan,
  input  logic [width-1:0]          c_data,
  output logic [channels-1:0]       c_fc_n,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [cw-1:0]             p_chan,
  output logic [width-1:0]          p_data,
  output logic [channels*asz-1:0]   usage,
  output logic [channels-1:0]       overflow,
  input  logic [channels-1:0]       ovf_clr
);

  localparam int pw = (depth > 1) ? $clog2(depth) : 1;

  logic                vld_q;
  logic [cw-1:0]       chan_q;
  logic [width-1:0]    data_q;

  logic [width-1:0]    mem    [channels][depth];
  logic [pw-1:0]       wr_ptr [channels];
  logic [pw-1:0]       rd_ptr [channels];
  logic [asz-1:0]      cnt    [channels];

  logic [channels-1:0] wr_en, wr_ok, ovf_set, nonempty, pop;
  logic [cw-1:0]       rr_ptr, grant, hi_idx, lo_idx;
  logic                grant_vld, hi_vld, lo_vld, load;

  function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
    return (p == pw'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= c_vld;
    chan_q <= c_chan;
    data_q <= c_data;
  end

  assign load = !p_srdy || p_drdy;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  always_comb begin
    wr_en    = '0;
    wr_ok    = '0;
    ovf_set  = '0;
    nonempty = '0;
    pop      = '0;
    for (int i = 0; i < channels; i++) begin
      wr_en[i]    = vld_q && (chan_q == cw'(i));
      wr_ok[i]    = wr_en[i] && (cnt[i] != asz'(depth));
      ovf_set[i]  = wr_en[i] && (cnt[i] == asz'(depth));
      nonempty[i] = (cnt[i] != '0);
      pop[i]      = load && grant_vld && (grant == cw'(i));
    end
  end

  // Search channels above the pointer first, then wrap to those at or below it.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < channels; i++) begin
      if (!hi_vld && nonempty[i] && (cw'(i) > rr_ptr)) begin
        hi_vld = 1'b1;
        hi_idx = cw'(i);
      end
      if (!lo_vld && nonempty[i] && (cw'(i) <= rr_ptr)) begin
        lo_vld = 1'b1;
        lo_idx = cw'(i);
      end
    end
    grant_vld = hi_vld || lo_vld;
    grant     = hi_vld ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < channels; i++) begin
      if (wr_ok[i]) mem[i][wr_ptr[i]] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < channels; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < channels; i++) begin
        if (wr_ok[i]) wr_ptr[i] <= next_ptr(wr_ptr[i]);
        if (pop[i])   rd_ptr[i] <= next_ptr(rd_ptr[i]);
        case ({wr_ok[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // fc_n is driven from the pre-update count, adding one cycle to the loop.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_fc_n   <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < channels; i++) begin
`ifdef DFC_RX_HYSTERESIS_EN
        if (int'(cnt[i]) >= threshold)         c_fc_n[i] <= 1'b0;
        else if (int'(cnt[i]) <= lo_threshold) c_fc_n[i] <= 1'b1;
`else
        c_fc_n[i] <= (int'(cnt[i]) < threshold);
`endif
        if (ovf_set[i])      overflow[i] <= 1'b1;
        else if (ovf_clr[i]) overflow[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy <= 1'b0;
      p_chan <= '0;
      p_data <= '0;
      rr_ptr <= cw'(channels - 1);
    end else if (load) begin
      if (grant_vld) begin
        p_srdy <= 1'b1;
        p_chan <= grant;
        p_data <= mem[grant][rd_ptr[grant]];
        rr_ptr <= grant;
      end else begin
        p_srdy <= 1'b0;
      end
    end
  end

  always_comb begin
    usage = '0;
    for (int i = 0; i < channels; i++) usage[i*asz +: asz] = cnt[i];
  end

endmodule

// File: tb/tb_dfc_mc_receiver.sv
// Scoreboard bench for dfc_mc_receiver: per-channel ordering, flow control, overflow, round robin.
`timescale 1ns/1ps
module tb_dfc_mc_receiver;
  localparam int width    = 8;
  localparam int channels = 4;
  localparam int depth    = 8;
`ifdef DFC_RX_HYSTERESIS_EN
  localparam int thr = 4;
`else
  localparam int thr = 2;
`endif
  localparam int lo  = 1;
  localparam int cw  = 2;
  localparam int asz = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    c_vld;
  logic [cw-1:0]           c_chan;
  logic [width-1:0]        c_data;
  logic [channels-1:0]     c_fc_n;
  logic                    p_srdy;
  logic                    p_drdy;
  logic [cw-1:0]           p_chan;
  logic [width-1:0]        p_data;
  logic [channels*asz-1:0] usage;
  logic [channels-1:0]     overflow;
  logic [channels-1:0]     ovf_clr;

  int tests_run  = 0;
  int fail_count = 0;
  logic [cw-1:0]    sb_chan [$];
  logic [width-1:0] sb_data [$];

  always #5 clk = ~clk;

  dfc_mc_receiver #(
    .width(width), .channels(channels), .depth(depth),
    .threshold(thr), .lo_threshold(lo)
  ) dut (
    .clk(clk), .reset(reset), .c_vld(c_vld), .c_chan(c_chan), .c_data(c_data),
    .c_fc_n(c_fc_n), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_chan(p_chan),
    .p_data(p_data), .usage(usage), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  function automatic logic [asz-1:0] use_of(input int ch);
    return usage[ch*asz +: asz];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [width-1:0] d, input bit kept);
    c_vld  = 1'b1;
    c_chan = cw'(ch);
    c_data = d;
    if (kept) begin
      sb_chan.push_back(cw'(ch));
      sb_data.push_back(d);
    end
    tick();
    c_vld = 1'b0;
  endtask

  // Park a ch3 word in the output register so later FIFO counts are exact.
  task automatic preload_hold(input logic [width-1:0] d);
    p_drdy = 1'b0;
    send(3, d, 1'b1);
    tick();
    tick();
  endtask

  task automatic drain(input int n);
    p_drdy = 1'b1;
    repeat (n) tick();
    p_drdy = 1'b0;
  endtask

  // Every accepted output word must match the oldest expected word of its channel.
  always @(negedge clk) begin
    if (!reset && p_srdy && p_drdy) begin
      int hit;
      hit = -1;
      for (int j = 0; j < sb_chan.size(); j++)
        if (hit < 0 && sb_chan[j] == p_chan) hit = j;
      tests_run++;
      if (hit < 0) begin
        fail_count++;
        $display("[TB] FAIL sb_unexpected: got chan %0d data %h, none expected", p_chan, p_data);
      end else begin
        if (p_data !== sb_data[hit]) begin
          fail_count++;
          $display("[TB] FAIL sb_data ch%0d: got %h expected %h", p_chan, p_data, sb_data[hit]);
        end
        sb_chan.delete(hit);
        sb_data.delete(hit);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; c_vld = 1'b0; c_chan = '0; c_data = '0; p_drdy = 1'b0; ovf_clr = '0;
    tick(); tick();
    reset = 1'b0;
    tests_run++; if (c_fc_n !== 4'h0) begin fail_count++; $display("[TB] FAIL reset_fc_n: got %h expected 0", c_fc_n); end
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_srdy: got %b expected 0", p_srdy); end
    tests_run++; if (usage !== '0) begin fail_count++; $display("[TB] FAIL reset_usage: got %h expected 0", usage); end
    tests_run++; if (overflow !== 4'h0) begin fail_count++; $display("[TB] FAIL reset_ovf: got %h expected 0", overflow); end
    tick();
    tests_run++; if (c_fc_n !== 4'hF) begin fail_count++; $display("[TB] FAIL idle_fc_n: got %h expected F", c_fc_n); end
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL idle_srdy: got %b expected 0", p_srdy); end
  endtask

  task automatic test_single_word();
    p_drdy = 1'b1;
    send(2, 8'hA5, 1'b1);
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL single_early1: got %b expected 0", p_srdy); end
    tick();
    tests_run++; if (use_of(2) !== 4'd1) begin fail_count++; $display("[TB] FAIL single_usage1: got %0d expected 1", use_of(2)); end
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL single_early2: got %b expected 0", p_srdy); end
    tick();
    tests_run++; if (p_srdy !== 1'b1) begin fail_count++; $display("[TB] FAIL single_srdy: got %b expected 1", p_srdy); end
    tests_run++; if (p_chan !== 2'd2) begin fail_count++; $display("[TB] FAIL single_chan: got %0d expected 2", p_chan); end
    tests_run++; if (p_data !== 8'hA5) begin fail_count++; $display("[TB] FAIL single_data: got %h expected a5", p_data); end
    tests_run++; if (use_of(2) !== 4'd0) begin fail_count++; $display("[TB] FAIL single_usage0: got %0d expected 0", use_of(2)); end
    tick();
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL single_done: got %b expected 0", p_srdy); end
    p_drdy = 1'b0;
  endtask

  task automatic test_threshold();
    preload_hold(8'h33);
    send(0, 8'h01, 1'b1);
    send(0, 8'h02, 1'b1);
    tick();
    tests_run++; if (use_of(0) !== 4'd2) begin fail_count++; $display("[TB] FAIL thr_usage2: got %0d expected 2", use_of(0)); end
    tests_run++; if (c_fc_n[0] !== 1'b1) begin fail_count++; $display("[TB] FAIL thr_fc_lag: got %b expected 1", c_fc_n[0]); end
    tick();
    tests_run++; if (c_fc_n[0] !== 1'b0) begin fail_count++; $display("[TB] FAIL thr_fc_low: got %b expected 0", c_fc_n[0]); end
    drain(1);
    tick();
    tests_run++; if (use_of(0) !== 4'd1) begin fail_count++; $display("[TB] FAIL thr_usage1: got %0d expected 1", use_of(0)); end
    tests_run++; if (c_fc_n[0] !== 1'b1) begin fail_count++; $display("[TB] FAIL thr_fc_high: got %b expected 1", c_fc_n[0]); end
    drain(4);
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL thr_drained: got %b expected 0", p_srdy); end
  endtask

  task automatic test_hysteresis();
    preload_hold(8'h44);
    for (int k = 0; k < 4; k++) send(0, 8'h50 + 8'(k), 1'b1);
    tick(); tick();
    tests_run++; if (use_of(0) !== 4'd4) begin fail_count++; $display("[TB] FAIL hys_usage4: got %0d expected 4", use_of(0)); end
    tests_run++; if (c_fc_n[0] !== 1'b0) begin fail_count++; $display("[TB] FAIL hys_fc_low: got %b expected 0", c_fc_n[0]); end
    drain(1); drain(1);
    tick(); tick();
    tests_run++; if (use_of(0) !== 4'd2) begin fail_count++; $display("[TB] FAIL hys_usage2: got %0d expected 2", use_of(0)); end
    tests_run++; if (c_fc_n[0] !== 1'b0) begin fail_count++; $display("[TB] FAIL hys_fc_hold: got %b expected 0", c_fc_n[0]); end
    drain(1);
    tick();
    tests_run++; if (c_fc_n[0] !== 1'b1) begin fail_count++; $display("[TB] FAIL hys_fc_release: got %b expected 1", c_fc_n[0]); end
    drain(4);
  endtask

  task automatic test_overflow();
    preload_hold(8'h99);
    for (int k = 0; k < 9; k++) send(1, 8'hC0 + 8'(k), k < 8);
    tick();
    tests_run++; if (use_of(1) !== 4'd8) begin fail_count++; $display("[TB] FAIL ovf_usage: got %0d expected 8", use_of(1)); end
    tests_run++; if (overflow !== 4'b0010) begin fail_count++; $display("[TB] FAIL ovf_flag: got %b expected 0010", overflow); end
    tick();
    tests_run++; if (overflow !== 4'b0010) begin fail_count++; $display("[TB] FAIL ovf_sticky: got %b expected 0010", overflow); end
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    tests_run++; if (overflow !== 4'b0000) begin fail_count++; $display("[TB] FAIL ovf_clear: got %b expected 0000", overflow); end
    drain(12);
    tests_run++; if (usage !== '0) begin fail_count++; $display("[TB] FAIL ovf_drained: got %h expected 0", usage); end
  endtask

  task automatic test_round_robin();
    int         exp_c [6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0] exp_d [6] = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
    p_drdy = 1'b0;
    send(0, 8'h10, 1'b1); send(0, 8'h11, 1'b1);
    send(1, 8'h20, 1'b1); send(1, 8'h21, 1'b1);
    send(3, 8'h30, 1'b1); send(3, 8'h31, 1'b1);
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      tests_run++; if (p_srdy !== 1'b1 || p_chan !== cw'(exp_c[k]) || p_data !== exp_d[k]) begin
        fail_count++; $display("[TB] FAIL rr_word%0d: got srdy %b chan %0d data %h expected 1 %0d %h", k, p_srdy, p_chan, p_data, exp_c[k], exp_d[k]);
      end
      if (k == 1 || k == 3) begin
        tick();
        tests_run++; if (p_srdy !== 1'b1 || p_chan !== cw'(exp_c[k]) || p_data !== exp_d[k]) begin
          fail_count++; $display("[TB] FAIL rr_stall%0d: got srdy %b chan %0d data %h expected 1 %0d %h", k, p_srdy, p_chan, p_data, exp_c[k], exp_d[k]);
        end
      end
      drain(1);
    end
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL rr_end: got %b expected 0", p_srdy); end
  endtask

  task automatic test_back_to_back();
    int waited;
    p_drdy = 1'b1;
    for (int k = 0; k < 8; k++) send($urandom_range(0, channels - 1), 8'($urandom), 1'b1);
    waited = 0;
    while (sb_chan.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    tests_run++; if (sb_chan.size() != 0) begin fail_count++; $display("[TB] FAIL b2b_timeout: got %0d pending expected 0", sb_chan.size()); end
    tests_run++; if (waited > 4) begin fail_count++; $display("[TB] FAIL b2b_rate: got %0d drain cycles expected <= 4", waited); end
    p_drdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    p_drdy = 1'b0;
    send(1, 8'hE0, 1'b0); send(1, 8'hE1, 1'b0); send(2, 8'hE2, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (usage !== '0) begin fail_count++; $display("[TB] FAIL mid_usage: got %h expected 0", usage); end
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL mid_srdy: got %b expected 0", p_srdy); end
    tests_run++; if (c_fc_n !== 4'h0) begin fail_count++; $display("[TB] FAIL mid_fc_n: got %h expected 0", c_fc_n); end
    drain(5);
    tests_run++; if (p_srdy !== 1'b0) begin fail_count++; $display("[TB] FAIL mid_no_emit: got %b expected 0", p_srdy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
`ifdef DFC_RX_HYSTERESIS_EN
    test_hysteresis();
`else
    test_threshold();
`endif
    test_overflow();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    tests_run++; if (sb_chan.size() != 0) begin fail_count++; $display("[TB] FAIL sb_leftover: got %0d expected 0", sb_chan.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
